// File: rtl/fc_accumulator.sv
// ============================================================================
// fc_accumulator : sums chunked FC partials plus bias, ReLU+saturate, 2-deep out queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module fc_accumulator #(
  parameter int WORD_SIZE          = 16,
  parameter int CHUNK_NUM          = 8,
  parameter int OUTPUT_CHANNEL_NUM = 100,
  parameter int ACC_WIDTH          = 24,
  localparam int IDX_W = (OUTPUT_CHANNEL_NUM > 1) ? $clog2(OUTPUT_CHANNEL_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_partial,
  input  logic [WORD_SIZE-1:0] i_bias,
  output logic                 o_in_ready,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_data,
  output logic [IDX_W-1:0]     o_index,
  input  logic                 i_ready,
  output logic                 o_layer_done,
  output logic                 o_overflow
);

  localparam int CNT_W = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
  localparam logic [CNT_W-1:0]     C_LAST_CHUNK  = CNT_W'(CHUNK_NUM - 1);
  localparam logic [IDX_W-1:0]     C_LAST_NEURON = IDX_W'(OUTPUT_CHANNEL_NUM - 1);
  localparam logic [ACC_WIDTH-1:0] C_POS_MAX     =
    {{(ACC_WIDTH-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] C_SAT         = {1'b0, {(WORD_SIZE-1){1'b1}}};

  logic [CNT_W-1:0]     r_chunk_cnt;
  logic [IDX_W-1:0]     r_neuron_cnt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [WORD_SIZE-1:0] r_mem_data [2];
  logic [IDX_W-1:0]     r_mem_idx  [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 r_layer_done;
  logic                 r_overflow;

  logic                 w_first;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [WORD_SIZE-1:0] w_act;
  logic                 w_in_ready;
  logic                 w_take;
  logic                 w_final;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;

  assign w_first = (r_chunk_cnt == '0);
  assign w_last  = (r_chunk_cnt == C_LAST_CHUNK);
  assign w_base  = w_first ? {{(ACC_WIDTH-WORD_SIZE){i_bias[WORD_SIZE-1]}}, i_bias} : r_acc;
  assign w_sum   = w_base + {{(ACC_WIDTH-WORD_SIZE){i_partial[WORD_SIZE-1]}}, i_partial};

  // Negative sums clamp to zero; positive sums beyond the word range clamp to max.
  assign w_act = w_sum[ACC_WIDTH-1]   ? '0    :
                 (w_sum > C_POS_MAX)  ? C_SAT :
                 w_sum[WORD_SIZE-1:0];

  assign w_in_ready = (r_count != 2'd2);
  assign w_take     = i_valid && !i_start;
  assign w_final    = w_take && w_last;
  assign w_push     = w_final && w_in_ready;
  assign w_drop     = w_final && !w_in_ready;
  assign w_pop      = (r_count != 2'd0) && i_ready;

  always_ff @(posedge clk) begin
    if (rst_n || i_start) begin
      r_chunk_cnt   <= '0;
      r_neuron_cnt  <= '0;
      r_acc         <= '0;
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_idx[0]  <= '0;
      r_mem_idx[1]  <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_layer_done  <= 1'b0;
    end else begin
      r_layer_done <= 1'b0;
      if (w_take) begin
        r_acc       <= w_sum;
        r_chunk_cnt <= w_last ? '0 : r_chunk_cnt + 1'b1;
      end
      // Neuron index advances even on a drop so it stays aligned with upstream.
      if (w_final) begin
        r_neuron_cnt <= (r_neuron_cnt == C_LAST_NEURON) ? '0 : r_neuron_cnt + 1'b1;
        r_layer_done <= (r_neuron_cnt == C_LAST_NEURON);
      end
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_act;
        r_mem_idx[r_wr_ptr]  <= r_neuron_cnt;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_valid      = (r_count != 2'd0);
  assign o_data       = r_mem_data[r_rd_ptr];
  assign o_index      = r_mem_idx[r_rd_ptr];
  assign o_layer_done = r_layer_done;
  assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fc_accumulator.sv
// ============================================================================
// tb_fc_accumulator : scenario tasks checked against a queue-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fc_accumulator;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int NCH = 100;
  localparam int AW  = 24;
  localparam int IW  = $clog2(NCH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_partial = '0;
  logic [W-1:0]  i_bias = '0;
  logic          i_ready = 1'b0;
  logic          o_in_ready;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic [IW-1:0] o_index;
  logic          o_layer_done;
  logic          o_overflow;

  fc_accumulator #(
    .WORD_SIZE(W), .CHUNK_NUM(CH), .OUTPUT_CHANNEL_NUM(NCH), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_partial(i_partial), .i_bias(i_bias), .o_in_ready(o_in_ready),
    .o_valid(o_valid), .o_data(o_data), .o_index(o_index), .i_ready(i_ready),
    .o_layer_done(o_layer_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } ent_t;

  ent_t   q[$];
  int     m_chunk = 0;
  int     m_idx = 0;
  longint m_sum = 0;
  bit     m_ovf = 0;
  bit     m_ld = 0;

  // Exact integer sum, wrapped to the accumulator width, then ReLU and clamp.
  function automatic logic [W-1:0] relu_sat(input longint s);
    longint m = longint'(1) << AW;
    longint w = s % m;
    if (w < 0) w += m;
    if (w >= m / 2) w -= m;
    if (w < 0) return '0;
    if (w > 32767) return 16'h7FFF;
    return w[W-1:0];
  endfunction

  task automatic tick();
    bit pop, rdy;
    @(posedge clk);
    if (rst_n) begin
      q.delete(); m_chunk = 0; m_idx = 0; m_ovf = 0; m_ld = 0;
    end else if (i_start) begin
      q.delete(); m_chunk = 0; m_idx = 0; m_ld = 0;
    end else begin
      pop  = (q.size() > 0) && i_ready;
      rdy  = (q.size() < 2);
      m_ld = 0;
      if (pop) void'(q.pop_front());
      if (i_valid) begin
        m_sum = (m_chunk == 0 ? longint'($signed(i_bias)) : m_sum) + longint'($signed(i_partial));
        if (m_chunk == CH - 1) begin
          if (rdy) q.push_back(ent_t'{idx: IW'(m_idx), data: relu_sat(m_sum)});
          else     m_ovf = 1;
          m_ld    = (m_idx == NCH - 1);
          m_idx   = (m_idx + 1) % NCH;
          m_chunk = 0;
        end else begin
          m_chunk++;
        end
      end
    end
    #1;
  endtask

  task automatic send_neuron(input logic [W-1:0] b, input logic [CH*W-1:0] ps);
    for (int k = 0; k < CH; k++) begin
      i_valid   = 1'b1;
      i_bias    = b;
      i_partial = ps[W*(CH-1-k) +: W];
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    vectors++;
    if ({o_valid, o_data, o_index, o_layer_done, o_overflow, o_in_ready} !==
        {1'b0, 16'h0000, 7'd0, 1'b0, 1'b0, 1'b1})
      begin miscompares++; $display("FAIL reset_state: got v=%b d=%h i=%0d ld=%b ovf=%b rdy=%b, want 0 0000 0 0 0 1",
        o_valid, o_data, o_index, o_layer_done, o_overflow, o_in_ready); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    send_neuron(16'h0010, {4{16'h0100}});
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd0, 16'h0410})
      begin miscompares++; $display("FAIL basic_head: got v=%b i=%0d d=%h, want 1 0 0410", o_valid, o_index, o_data); end
    tick();
    vectors++;
    if (o_valid !== 1'b0)
      begin miscompares++; $display("FAIL basic_pop: got v=%b, want 0", o_valid); end
  endtask

  task automatic test_relu_sat();
    i_ready = 1'b1;
    send_neuron(16'h8000, {4{16'h0001}});
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd1, 16'h0000})
      begin miscompares++; $display("FAIL relu_zero: got v=%b i=%0d d=%h, want 1 1 0000", o_valid, o_index, o_data); end
    send_neuron(16'h0000, {4{16'h7FFF}});
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd2, 16'h7FFF})
      begin miscompares++; $display("FAIL saturate: got v=%b i=%0d d=%h, want 1 2 7fff", o_valid, o_index, o_data); end
    tick();
  endtask

  task automatic test_overflow();
    i_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    send_neuron(16'h0001, {4{16'h0001}});
    send_neuron(16'h0002, {4{16'h0001}});
    vectors++;
    if ({o_in_ready, o_overflow} !== 2'b00)
      begin miscompares++; $display("FAIL ovf_full: got rdy=%b ovf=%b, want 0 0", o_in_ready, o_overflow); end
    send_neuron(16'h0003, {4{16'h0001}});
    vectors++;
    if ({o_overflow, o_valid, o_index, o_data} !== {1'b1, 1'b1, 7'd0, q[0].data} || m_ovf !== 1'b1)
      begin miscompares++; $display("FAIL ovf_drop: got ovf=%b v=%b i=%0d d=%h, want 1 1 0 %h",
        o_overflow, o_valid, o_index, o_data, q[0].data); end
    i_ready = 1'b1;
    tick();
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd1, 16'h0006})
      begin miscompares++; $display("FAIL ovf_drain1: got v=%b i=%0d d=%h, want 1 1 0006", o_valid, o_index, o_data); end
    tick();
    vectors++;
    if (o_valid !== 1'b0)
      begin miscompares++; $display("FAIL ovf_drain2: got v=%b, want 0", o_valid); end
    send_neuron(16'h0000, {16'h0001, 16'h0002, 16'h0003, 16'h0004});
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd3, 16'h000A})
      begin miscompares++; $display("FAIL ovf_next_idx: got v=%b i=%0d d=%h, want 1 3 000a", o_valid, o_index, o_data); end
    tick();
  endtask

  task automatic test_layer_done();
    int pulses = 0;
    int pulse_idx = -1;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n <= NCH; n++) begin
      for (int k = 0; k < CH; k++) begin
        i_valid   = 1'b1;
        i_bias    = W'($urandom);
        i_partial = W'($urandom);
        tick();
        if (o_layer_done) begin pulses++; pulse_idx = int'(o_index); end
      end
      i_valid = 1'b0;
      vectors++;
      if (q.size() == 0 || {o_valid, o_index, o_data} !== {1'b1, IW'(n % NCH), q[0].data})
        begin miscompares++; $display("FAIL layer_neuron%0d: got v=%b i=%0d d=%h, want 1 %0d model-q=%0d",
          n, o_valid, o_index, o_data, n % NCH, q.size()); end
    end
    vectors++;
    if (pulses != 1 || pulse_idx != NCH - 1)
      begin miscompares++; $display("FAIL layer_done: got %0d pulses at idx %0d, want 1 at %0d", pulses, pulse_idx, NCH - 1); end
    tick();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    i_valid = 1'b1; i_bias = 16'h1234; i_partial = 16'h0100;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0; i_valid = 1'b0;
    vectors++;
    if ({o_valid, o_data, o_index, o_layer_done, o_overflow, o_in_ready} !==
        {1'b0, 16'h0000, 7'd0, 1'b0, 1'b0, 1'b1})
      begin miscompares++; $display("FAIL reset_mid: got v=%b d=%h i=%0d ld=%b ovf=%b rdy=%b, want 0 0000 0 0 0 1",
        o_valid, o_data, o_index, o_layer_done, o_overflow, o_in_ready); end
    send_neuron(16'h0005, {16'h0001, 16'h0002, 16'h0003, 16'h0004});
    vectors++;
    if ({o_valid, o_index, o_data} !== {1'b1, 7'd0, 16'h000F})
      begin miscompares++; $display("FAIL reset_fresh: got v=%b i=%0d d=%h, want 1 0 000f", o_valid, o_index, o_data); end
    tick();
  endtask

  task automatic test_start_mid();
    i_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_neuron(16'h0001, {4{16'h0002}});
    i_valid = 1'b1; i_bias = 16'h0100; i_partial = 16'h0100;
    tick(); tick();
    i_start = 1'b1; i_partial = 16'h7000;
    tick();
    i_start = 1'b0; i_valid = 1'b0;
    vectors++;
    if ({o_valid, o_overflow, o_in_ready, o_layer_done} !== 4'b0110)
      begin miscompares++; $display("FAIL start_mid: got v=%b ovf=%b rdy=%b ld=%b, want 0 1 1 0",
        o_valid, o_overflow, o_in_ready, o_layer_done); end
    i_ready = 1'b1;
    send_neuron(16'h0020, {16'h0001, 16'h0002, 16'h0003, 16'h0004});
    vectors++;
    if ({o_valid, o_index, o_data, o_overflow} !== {1'b1, 7'd0, 16'h002A, 1'b1})
      begin miscompares++; $display("FAIL start_fresh: got v=%b i=%0d d=%h ovf=%b, want 1 0 002a 1",
        o_valid, o_index, o_data, o_overflow); end
    tick();
  endtask

  task automatic test_random();
    int gaps;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < CH; k++) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g <= gaps; g++) begin
          i_valid = (g == gaps);
          i_ready = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 3))
            0:       i_partial = 16'h8000;
            1:       i_partial = 16'h7FFF;
            default: i_partial = W'($urandom);
          endcase
          i_bias = W'($urandom);
          tick();
          vectors++;
          if (o_valid !== (q.size() > 0) || o_in_ready !== (q.size() < 2) ||
              o_overflow !== m_ovf || o_layer_done !== m_ld ||
              (q.size() > 0 && {o_index, o_data} !== {q[0].idx, q[0].data}))
            begin miscompares++; $display("FAIL random_n%0d_c%0d: got v=%b rdy=%b ovf=%b ld=%b i=%0d d=%h, want v=%b ovf=%b ld=%b head=%h",
              n, k, o_valid, o_in_ready, o_overflow, o_layer_done, o_index, o_data,
              q.size() > 0, m_ovf, m_ld, (q.size() > 0) ? q[0] : ent_t'(0)); end
        end
      end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_sat();
    test_overflow();
    test_layer_done();
    test_reset_mid();
    test_start_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fc_accumulator.md
Name: fc_accumulator

Overview:
- Sits directly downstream of the 16-channel fully-connected MAC stage and consumes its 16-bit `o_result` stream.
- Each output neuron's partial result arrives as `chunk_num` consecutive 16-channel partial sums. This block accumulates them, adds the neuron bias, applies ReLU and saturates to `word_size`.
- Finished activations are queued in a 2-entry output buffer and drained with a valid/ready handshake toward the next layer's feature memory.

Parameters:
- `word_size`, 16, width of partial sums, bias and output activation (signed two's complement).
- `chunk_num`, 8, partial sums per neuron (input features / 16).
- `output_channel_num`, 100, neurons per layer; sets index wrap and the `o_layer_done` point.
- `acc_width`, 24, internal signed accumulator width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-high (asserted = 1), sampled on the `clk` rising edge.
- `i_start`  in  1  one-cycle pulse; synchronously clears the chunk and neuron counters and the output buffer.
- `i_valid`  in  1  `i_partial` valid this cycle.
- `i_partial`  in  `word_size`  signed partial sum from the FC MAC stage.
- `i_bias`  in  `word_size`  signed bias of the current neuron; sampled only when `i_valid` is high and `chunk_cnt` = 0.
- `o_in_ready`  out  1  high when the buffer can accept a completed neuron (count < 2).
- `o_valid`  out  1  output buffer head valid.
- `o_data`  out  `word_size`  activation at the buffer head.
- `o_index`  out  clog2(`output_channel_num`)  neuron index of the head entry.
- `i_ready`  in  1  downstream accept.
- `o_layer_done`  out  1  one-cycle pulse when neuron `output_channel_num`-1 is pushed.
- `o_overflow`  out  1  sticky; set when a completed neuron is dropped.

Behaviour:
- Reset (`rst_n` = 1):
  - `chunk_cnt`, `neuron_cnt`, `acc`, buffer count and pointers all go to 0.
  - `o_valid`, `o_data`, `o_index`, `o_layer_done` and `o_overflow` go to 0.
  - `o_in_ready` = 1.
  - Reset overrides all other inputs, including mid-neuron; any partially accumulated neuron is discarded.
- `i_start`: same effect as reset except `o_overflow` is kept. If `i_start` and `i_valid` occur in the same cycle, `i_start` wins and the sample is ignored.
- Accumulate, on each cycle with `i_valid` high:
  - `chunk_cnt` = 0: `acc` <= sext(`i_bias`) + sext(`i_partial`).
  - 0 < `chunk_cnt` < `chunk_num`-1: `acc` <= `acc` + sext(`i_partial`).
  - `chunk_cnt` = `chunk_num`-1: `final` = `acc` + sext(`i_partial`) (`acc_width` bits, wraps, never saturates internally).
  - `chunk_cnt` increments and wraps to 0 after `chunk_num`-1.
  - If `chunk_num` = 1, bias plus partial is final in the same cycle.
- Activation on `final`:
  - `final` < 0 gives 0.
  - `final` > 2^(`word_size`-1)-1 gives 0x7FFF.
  - Otherwise `final`[`word_size`-1:0].
- Push:
  - On the final chunk, if `o_in_ready`, push {`neuron_cnt`, activation}.
  - `neuron_cnt` increments and wraps to 0 after `output_channel_num`-1; `o_layer_done` pulses in that same cycle.
  - If `o_in_ready` = 0, the entry is dropped and `o_overflow` is set. `neuron_cnt` still advances and `o_layer_done` still pulses, so indexing stays aligned with the upstream stream.
- Latency: final chunk accepted at edge N, so `o_valid`/`o_data` are visible after edge N (next cycle) when the buffer was empty.
- Output handshake:
  - Pop occurs when `o_valid` && `i_ready`.
  - `o_data`/`o_index` hold stable while `o_valid` && !`i_ready`.
  - Buffer order is FIFO.
- Simultaneous push and pop:
  - Count unchanged; legal at count 1.
  - At count 2, `o_in_ready` = 0, so the push is dropped even if a pop occurs that cycle.
  - `o_in_ready` is a function of registered count only (no combinational path from `i_ready`).
- Non-final chunks are always accepted regardless of buffer state.
- `i_valid` gaps of any length are allowed; there is no timeout.

Test Plan:
- `chunk_num`=4, bias=0x0010, partials 0x0100,0x0100,0x0100,0x0100, `i_ready`=1 -> one cycle after the 4th sample: `o_valid`=1, `o_data`=0x0410, `o_index`=0.
- bias=0x8000 (-32768), partials 0x0001 x4 -> `o_data`=0x0000 (ReLU); partials 0x7FFF x4, bias 0 -> `o_data`=0x7FFF (saturate).
- `i_ready`=0, three neurons completed back-to-back -> `o_in_ready` low after 2nd, 3rd dropped, `o_overflow`=1. Then `i_ready`=1 -> indices 0,1 drained in order; the next neuron gets index 3.
- Run 100 neurons with `i_ready`=1 -> `o_layer_done` pulses exactly once, on the push of index 99; the following neuron gets index 0.
- `rst_n` asserted after 2 of 4 chunks -> all outputs 0 next cycle. A fresh 4-chunk neuron then yields the correct value at index 0 with no residue.
- `i_start` together with `i_valid` mid-neuron -> sample ignored, counters 0, `o_overflow` retained, buffer emptied (`o_valid`=0 next cycle).
